// File: rtl/axi_burst_rw_master.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_rw_master
// Description : AXI4 master that runs one INCR write or read burst of 1-16
//               beats per user command. Write beats are paced to the user
//               through a stall handshake. Read beats are buffered and then
//               replayed to the user as one contiguous stream.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_rw_master #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int MAX_BEATS = 16
) (
    input  logic                  aclk_0,
    input  logic                  aresetn_0,
    // user command interface
    input  logic                  user_start_0,
    input  logic                  user_w_r_0,
    input  logic [ADDR_W-1:0]     user_addr_in_0,
    input  logic [3:0]            user_burst_len_in_0,
    input  logic [DATA_W/8-1:0]   user_data_strb_0,
    input  logic [DATA_W-1:0]     user_data_in_0,
    output logic                  user_stall_w_data_0,
    output logic [DATA_W-1:0]     user_data_out_0,
    output logic                  user_data_out_en_0,
    output logic                  user_stall_r_data_0,
    output logic                  user_free_0,
    output logic [1:0]            user_status_0,
    // AXI write address channel
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    // AXI write data channel
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    // AXI write response channel
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    // AXI read address channel
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    // AXI read data channel
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam logic [2:0] c_SIZE       = 3'($clog2(DATA_W/8));
    localparam logic [1:0] c_BURST_INCR = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_ADDR = 3'd1,
        S_WR_DATA = 3'd2,
        S_WR_RESP = 3'd3,
        S_RD_ADDR = 3'd4,
        S_RD_DATA = 3'd5,
        S_RD_OUT  = 3'd6
    } state_t;

    state_t                r_state;
    logic [3:0]            r_len;
    logic [3:0]            r_wr_beat;
    logic [3:0]            r_rd_beat;
    logic [4:0]            r_out_idx;
    logic [1:0]            r_rresp_max;
    logic [ADDR_W-1:0]     r_awaddr;
    logic [ADDR_W-1:0]     r_araddr;
    logic                  r_awvalid;
    logic                  r_arvalid;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_wstrb;
    logic                  r_wlast;
    logic                  r_wvalid;
    logic                  r_bready;
    logic                  r_rready;
    logic                  r_stall_w;
    logic                  r_stall_r;
    logic                  r_free;
    logic [1:0]            r_status;
    logic [DATA_W-1:0]     r_data_out;
    logic                  r_data_out_en;
    logic [DATA_W-1:0]     r_rbuf [MAX_BEATS];

    logic [1:0]            w_rresp_max;
    logic [4:0]            w_beats_total;

    // Worst read response seen so far, including the beat on the bus now
    always_comb begin
        w_rresp_max   = (m_axi_rresp > r_rresp_max) ? m_axi_rresp : r_rresp_max;
        w_beats_total = {1'b0, r_len} + 5'd1;
    end

    // Main control FSM; every user and AXI output is registered here
    always_ff @(posedge aclk_0 or posedge aresetn_0) begin
        if (aresetn_0) begin
            r_state       <= S_IDLE;
            r_len         <= 4'd0;
            r_wr_beat     <= 4'd0;
            r_rd_beat     <= 4'd0;
            r_out_idx     <= 5'd0;
            r_rresp_max   <= 2'b00;
            r_awaddr      <= '0;
            r_araddr      <= '0;
            r_awvalid     <= 1'b0;
            r_arvalid     <= 1'b0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_wlast       <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_rready      <= 1'b0;
            r_stall_w     <= 1'b0;
            r_stall_r     <= 1'b0;
            r_free        <= 1'b1;
            r_status      <= 2'b00;
            r_data_out    <= '0;
            r_data_out_en <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (user_start_0) begin
                        r_len     <= user_burst_len_in_0;
                        r_free    <= 1'b0;
                        r_wr_beat <= 4'd0;
                        r_rd_beat <= 4'd0;
                        if (user_w_r_0) begin
                            r_araddr    <= user_addr_in_0;
                            r_arvalid   <= 1'b1;
                            r_stall_r   <= 1'b1;
                            r_rresp_max <= 2'b00;
                            r_state     <= S_RD_ADDR;
                        end else begin
                            r_awaddr  <= user_addr_in_0;
                            r_awvalid <= 1'b1;
                            r_wdata   <= user_data_in_0;
                            r_wstrb   <= user_data_strb_0;
                            r_stall_w <= 1'b1;
                            r_state   <= S_WR_ADDR;
                        end
                    end
                end
                S_WR_ADDR: begin
                    if (m_axi_awready) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b1;
                        r_wlast   <= (r_len == 4'd0);
                        r_state   <= S_WR_DATA;
                    end
                end
                S_WR_DATA: begin
                    if (r_wvalid) begin
                        if (m_axi_wready) begin
                            // Beat accepted: open the one-cycle window for the next beat
                            r_wvalid  <= 1'b0;
                            r_wlast   <= 1'b0;
                            r_stall_w <= 1'b0;
                            if (r_wlast) begin
                                r_bready <= 1'b1;
                                r_state  <= S_WR_RESP;
                            end else begin
                                r_wr_beat <= r_wr_beat + 4'd1;
                            end
                        end
                    end else begin
                        // Window cycle: the user has updated its data, take it
                        r_wdata   <= user_data_in_0;
                        r_wvalid  <= 1'b1;
                        r_stall_w <= 1'b1;
                        r_wlast   <= (r_wr_beat == r_len);
                    end
                end
                S_WR_RESP: begin
                    if (m_axi_bvalid) begin
                        r_bready <= 1'b0;
                        r_status <= m_axi_bresp;
                        r_free   <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                S_RD_ADDR: begin
                    if (m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (m_axi_rvalid) begin
                        r_rd_beat <= r_rd_beat + 4'd1;
                        if (m_axi_rlast) begin
                            // Beat 0 may be arriving right now for a single-beat burst
                            r_rready      <= 1'b0;
                            r_status      <= w_rresp_max;
                            r_stall_r     <= 1'b0;
                            r_data_out    <= (r_rd_beat == 4'd0) ? m_axi_rdata : r_rbuf[0];
                            r_data_out_en <= 1'b1;
                            r_out_idx     <= 5'd1;
                            r_state       <= S_RD_OUT;
                        end else begin
                            r_rresp_max <= w_rresp_max;
                        end
                    end
                end
                S_RD_OUT: begin
                    if (r_out_idx == w_beats_total) begin
                        r_data_out_en <= 1'b0;
                        r_free        <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_data_out <= r_rbuf[r_out_idx[3:0]];
                        r_out_idx  <= r_out_idx + 5'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Read beat buffer; contents are only meaningful after a completed burst
    always_ff @(posedge aclk_0) begin
        if (r_state == S_RD_DATA && m_axi_rvalid) begin
            r_rbuf[r_rd_beat] <= m_axi_rdata;
        end
    end

    assign m_axi_awaddr        = r_awaddr;
    assign m_axi_awlen         = {4'b0000, r_len};
    assign m_axi_awsize        = c_SIZE;
    assign m_axi_awburst       = c_BURST_INCR;
    assign m_axi_awvalid       = r_awvalid;
    assign m_axi_wdata         = r_wdata;
    assign m_axi_wstrb         = r_wstrb;
    assign m_axi_wlast         = r_wlast;
    assign m_axi_wvalid        = r_wvalid;
    assign m_axi_bready        = r_bready;
    assign m_axi_araddr        = r_araddr;
    assign m_axi_arlen         = {4'b0000, r_len};
    assign m_axi_arsize        = c_SIZE;
    assign m_axi_arburst       = c_BURST_INCR;
    assign m_axi_arvalid       = r_arvalid;
    assign m_axi_rready        = r_rready;
    assign user_stall_w_data_0 = r_stall_w;
    assign user_stall_r_data_0 = r_stall_r;
    assign user_free_0         = r_free;
    assign user_status_0       = r_status;
    assign user_data_out_0     = r_data_out;
    assign user_data_out_en_0  = r_data_out_en;

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_rw_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_burst_rw_master
// Description : Randomized self-checking bench for axi_burst_rw_master with a
//               behavioural AXI slave and a user-level memory reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_burst_rw_master;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int STRB_W = DATA_W / 8;

    logic aclk = 1'b0;
    logic rst  = 1'b1;
    always #5 aclk = ~aclk;

    logic              user_start = 1'b0, user_w_r = 1'b0;
    logic [ADDR_W-1:0] user_addr = '0;
    logic [3:0]        user_len = '0;
    logic [STRB_W-1:0] user_strb = '0;
    logic [DATA_W-1:0] user_din = '0;
    logic              stall_w, stall_r, dout_en, user_free;
    logic [DATA_W-1:0] dout;
    logic [1:0]        status;

    logic [ADDR_W-1:0] awaddr, araddr;
    logic [7:0]        awlen, arlen;
    logic [2:0]        awsize, arsize;
    logic [1:0]        awburst, arburst;
    logic              awvalid, arvalid, wvalid, wlast, bready, rready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              awready, wready, bvalid, arready, rvalid, rlast;
    logic [1:0]        bresp, rresp;
    logic [DATA_W-1:0] rdata;

    axi_burst_rw_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BEATS(16)) dut (
        .aclk_0(aclk), .aresetn_0(rst),
        .user_start_0(user_start), .user_w_r_0(user_w_r),
        .user_addr_in_0(user_addr), .user_burst_len_in_0(user_len),
        .user_data_strb_0(user_strb), .user_data_in_0(user_din),
        .user_stall_w_data_0(stall_w), .user_data_out_0(dout),
        .user_data_out_en_0(dout_en), .user_stall_r_data_0(stall_r),
        .user_free_0(user_free), .user_status_0(status),
        .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // User-level reference memory: byte-merged with strobes, 0 where never written
    logic [63:0] ref_mem [bit [31:0]];
    logic [63:0] slv_mem [bit [31:0]];

    function automatic logic [63:0] ref_rd(input bit [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 64'h0;
    endfunction

    function automatic logic [63:0] slv_rd(input bit [31:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : 64'h0;
    endfunction

    // Slave configuration and expectations set by the user-side driver
    bit          bp = 1'b0;
    logic [1:0]  cfg_bresp = 2'b00;
    int          cfg_err_beat = 99;
    logic [1:0]  cfg_err_resp = 2'b00;
    logic [31:0] exp_addr;
    logic [3:0]  exp_len;
    logic [7:0]  exp_strb;
    logic [63:0] exp_wdata [16];
    int          aw_count = 0;
    int          w_idx = 0;

    // Behavioural AXI slave: decides readies/valids at the falling edge, so any
    // valid&&ready pair seen here is exactly what the next rising edge samples
    initial begin : slave
        bit          b_pend, b_hs, ar_pend, rd_active, r_hs;
        int          r_idx, rd_len;
        logic [31:0] rd_addr, wr_addr;
        logic [63:0] tmp;
        b_pend = 0; b_hs = 0; ar_pend = 0; rd_active = 0; r_hs = 0;
        r_idx = 0; rd_len = 0; rd_addr = '0; wr_addr = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = '0; rresp = 0; rlast = 0;
        forever begin
            @(negedge aclk);
            if (rst) begin
                b_pend = 0; b_hs = 0; ar_pend = 0; rd_active = 0; r_hs = 0;
                w_idx = 0; bvalid = 0; rvalid = 0; rlast = 0;
                awready = 0; wready = 0; arready = 0;
                continue;
            end
            // write response
            if (b_hs) begin bvalid = 0; b_hs = 0; end
            if (b_pend && !bvalid && (!bp || $urandom_range(1, 0) == 1)) begin
                bvalid = 1; bresp = cfg_bresp; b_pend = 0;
            end
            b_hs = bvalid && bready;
            // write address
            awready = bp ? ($urandom_range(2, 0) != 0) : 1'b1;
            if (awvalid && awready) begin
                aw_count++;
                w_idx   = 0;
                wr_addr = awaddr;
                check_val("awaddr", 64'(awaddr), 64'(exp_addr));
                check_val("awlen", 64'(awlen), 64'(exp_len));
                check_val("awsize", 64'(awsize), 64'd3);
                check_val("awburst", 64'(awburst), 64'd1);
            end
            // write data
            wready = bp ? ($urandom_range(2, 0) != 0) : 1'b1;
            if (wvalid && wready) begin
                if (w_idx < 16) begin
                    check_val("wdata", wdata, exp_wdata[w_idx]);
                    check_val("wstrb", 64'(wstrb), 64'(exp_strb));
                    check_val("wlast", 64'(wlast), 64'(w_idx == int'(exp_len)));
                end
                tmp = slv_rd(wr_addr + 32'(8 * w_idx));
                for (int b = 0; b < STRB_W; b++)
                    if (wstrb[b]) tmp[b*8 +: 8] = wdata[b*8 +: 8];
                slv_mem[wr_addr + 32'(8 * w_idx)] = tmp;
                if (wlast) b_pend = 1;
                w_idx++;
            end
            // read data / address
            if (r_hs) begin
                rvalid = 0; r_hs = 0; r_idx++;
                if (r_idx > rd_len) rd_active = 0;
            end
            if (ar_pend) begin rd_active = 1; r_idx = 0; ar_pend = 0; end
            arready = bp ? ($urandom_range(2, 0) != 0) : 1'b1;
            if (arvalid && arready) begin
                check_val("araddr", 64'(araddr), 64'(exp_addr));
                check_val("arlen", 64'(arlen), 64'(exp_len));
                check_val("arsize", 64'(arsize), 64'd3);
                check_val("arburst", 64'(arburst), 64'd1);
                rd_addr = araddr; rd_len = int'(arlen); ar_pend = 1;
            end
            if (rd_active && !rvalid && (!bp || $urandom_range(2, 0) != 0)) begin
                rvalid = 1;
                rdata  = slv_rd(rd_addr + 32'(8 * r_idx));
                rlast  = (r_idx == rd_len);
                rresp  = (r_idx == cfg_err_beat) ? cfg_err_resp : 2'b00;
            end
            r_hs = rvalid && rready;
        end
    end

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) exp_wdata[i] = {$urandom, $urandom};
    endtask

    task automatic wait_free();
        int cyc = 0;
        while (!user_free && cyc < 2000) begin @(negedge aclk); cyc++; end
        check_val("free_wait", 64'(user_free), 64'd1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] len,
                            input logic [7:0] strb, input logic [1:0] resp);
        int cyc = 0, falls = 0;
        bit prev = 0;
        logic [63:0] tmp;
        exp_addr = addr; exp_len = len; exp_strb = strb; cfg_bresp = resp;
        wait_free();
        user_start = 1; user_w_r = 0; user_addr = addr; user_len = len;
        user_strb = strb; user_din = exp_wdata[0];
        @(negedge aclk);
        user_start = 0;
        while (!user_free && cyc < 2000) begin
            if (prev && !stall_w) begin
                falls++;
                if (falls <= int'(len)) user_din = exp_wdata[falls];
            end
            prev = stall_w;
            @(negedge aclk);
            cyc++;
        end
        check_val("wr_done", 64'(user_free), 64'd1);
        check_val("wr_stall_falls", 64'(falls), 64'(int'(len) + 1));
        check_val("wr_beats", 64'(w_idx), 64'(int'(len) + 1));
        check_val("wr_status", 64'(status), 64'(resp));
        for (int i = 0; i <= int'(len); i++) begin
            tmp = ref_rd(addr + 32'(8 * i));
            for (int b = 0; b < STRB_W; b++)
                if (strb[b]) tmp[b*8 +: 8] = exp_wdata[i][b*8 +: 8];
            ref_mem[addr + 32'(8 * i)] = tmp;
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] len,
                           input int err_beat, input logic [1:0] err_resp, input bit poke);
        int cyc = 0, k = 0, bad_stall = 0, gaps = 0, aw0;
        bit prev_en = 0;
        exp_addr = addr; exp_len = len;
        cfg_err_beat = err_beat; cfg_err_resp = err_resp;
        wait_free();
        aw0 = aw_count;
        user_start = 1; user_w_r = 1; user_addr = addr; user_len = len;
        @(negedge aclk);
        user_start = 0;
        while (!user_free && cyc < 2000) begin
            // a command pulse while busy must be ignored
            user_start = poke && (cyc == 3);
            user_w_r   = !(poke && (cyc == 3));
            if (stall_r === dout_en) bad_stall++;
            if (dout_en) begin
                if (k > 0 && !prev_en) gaps++;
                if (k <= int'(len))
                    check_val("rd_data", dout, ref_rd(addr + 32'(8 * k)));
                k++;
            end
            prev_en = dout_en;
            @(negedge aclk);
            cyc++;
        end
        user_start = 0;
        check_val("rd_done", 64'(user_free), 64'd1);
        check_val("rd_beats", 64'(k), 64'(int'(len) + 1));
        check_val("rd_stall_pacing", 64'(bad_stall), 64'd0);
        check_val("rd_en_gaps", 64'(gaps), 64'd0);
        check_val("rd_status", 64'(status), 64'((err_beat <= int'(len)) ? err_resp : 2'b00));
        if (poke) check_val("busy_start_ignored", 64'(aw_count), 64'(aw0));
    endtask

    initial begin : stim
        int cyc, falls;
        bit prev;
        logic [31:0] a;
        repeat (3) @(negedge aclk);
        // reset state
        check_val("rst_free", 64'(user_free), 64'd1);
        check_val("rst_awvalid", 64'(awvalid), 64'd0);
        check_val("rst_wvalid", 64'(wvalid), 64'd0);
        check_val("rst_arvalid", 64'(arvalid), 64'd0);
        check_val("rst_bready", 64'(bready), 64'd0);
        check_val("rst_rready", 64'(rready), 64'd0);
        check_val("rst_stall_w", 64'(stall_w), 64'd0);
        check_val("rst_stall_r", 64'(stall_r), 64'd0);
        check_val("rst_dout_en", 64'(dout_en), 64'd0);
        check_val("rst_dout", dout, 64'd0);
        check_val("rst_status", 64'(status), 64'd0);
        check_val("rst_awaddr", 64'(awaddr), 64'd0);
        rst = 0;
        @(negedge aclk);

        // single beat write and readback
        exp_wdata[0] = 64'h00000000_F8F4F2F1;
        do_write(32'h1000_0000, 4'd0, 8'hFF, 2'b00);
        do_read(32'h1000_0000, 4'd0, 99, 2'b00, 1'b0);

        // full 16 beat burst
        fill_random(16);
        do_write(32'h1000_0080, 4'd15, 8'hFF, 2'b00);
        do_read(32'h1000_0080, 4'd15, 99, 2'b00, 1'b0);

        // partial strobe over previously written data
        fill_random(16);
        do_write(32'h1000_0080, 4'd15, 8'h0F, 2'b00);
        do_read(32'h1000_0080, 4'd15, 99, 2'b00, 1'b0);
        fill_random(16);
        do_write(32'h2000_0CC0, 4'd15, 8'h0F, 2'b00);
        do_read(32'h2000_0CC0, 4'd15, 99, 2'b00, 1'b0);

        // error responses, then a clean read clears status
        fill_random(4);
        do_write(32'h4000_0000, 4'd3, 8'hFF, 2'b10);
        do_read(32'h4000_0000, 4'd3, 2, 2'b11, 1'b0);
        do_read(32'h4000_0000, 4'd3, 1, 2'b01, 1'b0);
        do_read(32'h4000_0000, 4'd3, 99, 2'b00, 1'b0);

        // randomized backpressure on long and short bursts
        bp = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = 32'h5000_0000 + 32'(i * 256);
            fill_random(16);
            do_write(a, (i < 4) ? 4'd15 : 4'($urandom_range(15, 0)),
                     8'($urandom_range(255, 1)), 2'b00);
            do_read(a, 4'd15, int'($urandom_range(20, 0)), 2'b10, i == 2);
        end
        bp = 1'b0;

        // reset in the middle of a write burst
        fill_random(16);
        exp_addr = 32'h3000_0000; exp_len = 4'd15; exp_strb = 8'hFF;
        wait_free();
        user_start = 1; user_w_r = 0; user_addr = exp_addr; user_len = 4'd15;
        user_strb = 8'hFF; user_din = exp_wdata[0];
        @(negedge aclk);
        user_start = 0;
        cyc = 0; falls = 0; prev = 0;
        while (falls < 5 && cyc < 2000) begin
            if (prev && !stall_w) begin falls++; user_din = exp_wdata[falls]; end
            prev = stall_w;
            if (falls < 5) begin @(negedge aclk); cyc++; end
        end
        check_val("abort_reached_beat5", 64'(falls), 64'd5);
        @(posedge aclk);
        #2;
        check_val("abort_busy", 64'(user_free), 64'd0);
        rst = 1;
        #1;
        check_val("abort_awvalid", 64'(awvalid), 64'd0);
        check_val("abort_wvalid", 64'(wvalid), 64'd0);
        check_val("abort_bready", 64'(bready), 64'd0);
        check_val("abort_free", 64'(user_free), 64'd1);
        check_val("abort_stall_w", 64'(stall_w), 64'd0);
        repeat (2) @(negedge aclk);
        rst = 0;
        @(negedge aclk);

        // machine is fully usable after the abort
        fill_random(2);
        do_write(32'h6000_0000, 4'd1, 8'hFF, 2'b00);
        do_read(32'h6000_0000, 4'd1, 99, 2'b00, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_burst_rw_master.md
Name: axi_burst_rw_master

Overview:
- AXI4 burst master driven by a simple user command interface.
- Performs single INCR write or read bursts of 1–16 beats of DATA_W bits, addressed by the user.
- Sits between user logic (traffic generator / test logic) and an AXI4 slave, memory or interconnect.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 64, data width; strobe width is DATA_W/8.
- MAX_BEATS, 16, read buffer depth; equals maximum burst length.

Ports:
- aclk_0  in  1  clock, all logic on rising edge.
- aresetn_0  in  1  asynchronous, active-high reset (legacy name kept; asserted = 1).
- user_start_0  in  1  one-cycle command pulse, honoured only while user_free_0=1.
- user_w_r_0  in  1  0=write, 1=read; sampled with start.
- user_addr_in_0  in  ADDR_W  burst start address; sampled with start.
- user_burst_len_in_0  in  4  beats-1 (AXI LEN); sampled with start.
- user_data_strb_0  in  DATA_W/8  write strobe applied to every beat; sampled with start.
- user_data_in_0  in  DATA_W  write data for the current beat.
- user_stall_w_data_0  out  1  write-beat pacing, see Behaviour.
- user_data_out_0  out  DATA_W  read data beat.
- user_data_out_en_0  out  1  user_data_out_0 valid.
- user_stall_r_data_0  out  1  high while read data is not yet available to the user.
- user_free_0  out  1  idle, ready for a command.
- user_status_0  out  2  response of last completed transaction (BRESP, or worst RRESP).
- m_axi_aw{addr[ADDR_W],len[8],size[3],burst[2],valid} out; m_axi_awready in.
- m_axi_w{data[DATA_W],strb[DATA_W/8],last,valid} out; m_axi_wready in.
- m_axi_b{resp[2],valid} in; m_axi_bready out.
- m_axi_ar{addr[ADDR_W],len[8],size[3],burst[2],valid} out; m_axi_arready in.
- m_axi_r{data[DATA_W],resp[2],last,valid} in; m_axi_rready out.

Behaviour:
- Reset values: all valids/readies 0, user_free_0=1, both stalls 0, data_out_en 0, data_out 0, status 0, AXI address/data 0. Reset mid-transaction aborts immediately to IDLE.
- FSM states: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, RD_OUT.
- IDLE: start=1 captures addr, len, strb, w_r and user_data_in_0 (beat 0). Next cycle user_free_0=0. Start while busy is ignored.
- AW/AR fields: len = {4'b0, len_in}; size = log2(DATA_W/8) (3); burst = INCR (01). Addresses pass unchanged; 4KB-boundary legality is the user's responsibility.
- Write sequence:
  - WR_ADDR: awvalid=1 until awready.
  - WR_DATA: wvalid=1 with the captured beat and the captured strobe; wlast on beat len.
  - user_stall_w_data_0 is 1 from the cycle after start while a beat is held on W. It drops to 0 in the cycle after each W handshake.
  - While stall=0 (exactly one cycle), the user updates user_data_in_0. The block samples it at the next edge as the next beat and re-raises stall.
  - After the last handshake, stall falls once more and is not re-raised. The user therefore sees exactly len+1 falling edges.
  - WR_RESP: bready=1; on bvalid, status<=bresp, go to IDLE, user_free_0=1.
- Read sequence:
  - RD_ADDR: arvalid until arready.
  - RD_DATA: rready=1; beats stored in a MAX_BEATS×DATA_W buffer. status<=max(rresp) over the burst.
  - user_stall_r_data_0 is 1 from the cycle after start until all beats (rlast) are stored.
  - RD_OUT: stall falls, and in that same cycle user_data_out_0=beat0 and data_out_en=1. Each following cycle presents the next beat, for len+1 consecutive cycles. en drops after the last beat.
  - Then IDLE, user_free_0=1.
- All handshakes follow AXI: valid held stable until ready, no combinational ready→valid paths.

Test Plan:
- Single write: addr 0x10000000, len 0, data 0xF8F4F2F1, strb 0xFF, awready/wready=1 → AW len0 size3 burst1, one W beat with wlast, status 00, free returns to 1. Read back → one en beat 0xF8F4F2F1.
- 16-beat burst: write 0x10000080, len 15, data 0xA,0xBA,…,0x0 → 16 stall falling edges, wlast on 16th. Read → stall_r falls, 16 consecutive en cycles matching in order.
- Backpressure: random wready/awready/rvalid gaps on len-15 bursts → no beat lost or duplicated, stall pacing holds, data intact.
- Partial strobe: write 0x20000CC0, len 15, strb 0x0F → wstrb=0x0F on every beat; readback low 32 bits match.
- Error response: slave returns bresp=10 or one rresp=11 → user_status_0 = 10 / 11 after completion.
- Reset mid write burst (after beat 5) → all valids 0 within same edge, free=1. Start pulsed while busy → ignored.
